sec_to_hms: RTL

SEC_TO_HMS -- requirements
Module: sec_to_hms

---
 rtl/hms_pkg.sv | 21 ++
 rtl/bin2bcd_2dig.sv | 32 +++
 rtl/sec_to_hms.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hms_pkg.sv
// rtl/hms_pkg.sv - shared types and constants for the seconds-to-h:m:s converter
package hms_pkg;

    // Conversion sequence: wait, strip hours, strip minutes, publish
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HR   = 2'd1,
        MN   = 2'd2,
        DN   = 2'd3
    } hms_state_t;

    localparam int REM_W = 17;
    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [REM_W-1:0] SEC_PER_HR  = 17'd3600;
    localparam logic [REM_W-1:0] SEC_PER_MIN = 17'd60;
    localparam logic [REM_W-1:0] DEF_MAX_SEC = 17'd86400;

endpackage

// File: rtl/bin2bcd_2dig.sv
// rtl/bin2bcd_2dig.sv - combinational 0..59 binary to two-digit BCD
module bin2bcd_2dig (
    input  logic [5:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] tens_x10_lo;

    // Tens digit by range compare; the ones digit only needs the low nibble
    // of bin - 10*tens, since the true difference is always below 10.
    always_comb begin
        tens = 4'd0;
        if (bin >= 6'd50)      tens = 4'd5;
        else if (bin >= 6'd40) tens = 4'd4;
        else if (bin >= 6'd30) tens = 4'd3;
        else if (bin >= 6'd20) tens = 4'd2;
        else if (bin >= 6'd10) tens = 4'd1;

        case (tens)
            4'd1:    tens_x10_lo = 4'd10;
            4'd2:    tens_x10_lo = 4'd4;
            4'd3:    tens_x10_lo = 4'd14;
            4'd4:    tens_x10_lo = 4'd8;
            4'd5:    tens_x10_lo = 4'd2;
            default: tens_x10_lo = 4'd0;
        endcase

        bcd = {tens, bin[3:0] - tens_x10_lo};
    end

endmodule

// File: rtl/sec_to_hms.sv
// rtl/sec_to_hms.sv - iterative seconds to hours/minutes/seconds converter (HMS_BCD_EN adds bcd_out)
module sec_to_hms
    import hms_pkg::*;
#(
    parameter logic [REM_W-1:0] MAX_SEC = DEF_MAX_SEC
) (
    input  logic              hms_clk,
    input  logic              hms_rst,
    input  logic              start,
    input  logic [REM_W-1:0]  sec_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [HR_W-1:0]   hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds
`ifdef HMS_BCD_EN
    ,
    output logic [23:0]       bcd_out
`endif
);

    hms_state_t         state;
    hms_state_t         state_nxt;
    logic [REM_W-1:0]   rem;
    logic [HR_W-1:0]    h;
    logic [MIN_W-1:0]   m;
    logic               err_flag;

    logic accept;
    logic over_range;

    assign accept     = (state == IDLE) && start;
    assign over_range = (sec_in > MAX_SEC);

`ifdef HMS_BCD_EN
    logic [7:0] bcd_h;
    logic [7:0] bcd_m;
    logic [7:0] bcd_s;

    bin2bcd_2dig u_bcd_h (.bin({1'b0, h}), .bcd(bcd_h));
    bin2bcd_2dig u_bcd_m (.bin(m),         .bcd(bcd_m));
    bin2bcd_2dig u_bcd_s (.bin(rem[5:0]),  .bcd(bcd_s));
`endif

    // State register
    always_ff @(posedge hms_clk or posedge hms_rst) begin
        if (hms_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state: each subtract is guarded by its compare, so rem never wraps
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = over_range ? DN : HR;
            HR:   if (rem < SEC_PER_HR)  state_nxt = MN;
            MN:   if (rem < SEC_PER_MIN) state_nxt = DN;
            DN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status output decoded from state
    always_comb begin
        busy = 1'b0;
        if (state != IDLE) busy = 1'b1;
    end

    // Datapath: capture, repeated subtraction, and result publication in DN
    always_ff @(posedge hms_clk or posedge hms_rst) begin
        if (hms_rst) begin
            rem      <= '0;
            h        <= '0;
            m        <= '0;
            err_flag <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            hours    <= '0;
            minutes  <= '0;
            seconds  <= '0;
`ifdef HMS_BCD_EN
            bcd_out  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem      <= sec_in;
                        h        <= '0;
                        m        <= '0;
                        err_flag <= over_range;
                        err      <= 1'b0;
                    end
                end
                HR: begin
                    if (rem >= SEC_PER_HR) begin
                        rem <= rem - SEC_PER_HR;
                        h   <= h + 5'd1;
                    end
                end
                MN: begin
                    if (rem >= SEC_PER_MIN) begin
                        rem <= rem - SEC_PER_MIN;
                        m   <= m + 6'd1;
                    end
                end
                DN: begin
                    done <= 1'b1;
                    if (err_flag) begin
                        err     <= 1'b1;
                        hours   <= '0;
                        minutes <= '0;
                        seconds <= '0;
`ifdef HMS_BCD_EN
                        bcd_out <= '0;
`endif
                    end else begin
                        hours   <= h;
                        minutes <= m;
                        seconds <= rem[5:0];
`ifdef HMS_BCD_EN
                        bcd_out <= {bcd_h, bcd_m, bcd_s};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
